// File: rtl/grv_sample_streamer.sv
// Pair-wide FIFO behind the Box-Muller generator, serialised as a 16-bit
// valid/ready sample stream (grv1 then grv2 of each pair).
module grv_sample_streamer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [15:0]   in_grv1,
    input  logic [15:0]   in_grv2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic          out_sel,
    output logic [AW:0]   fill_level,
    output logic [15:0]   overflow_cnt
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   head;
    logic          full;
    logic          accept;
    logic          pop;
    logic          half;
    logic          push;
    logic          drop;

    always_comb begin
        full      = (fill_level == (AW+1)'(DEPTH));
        out_valid = (fill_level != '0);
        accept    = out_valid & out_ready;
        pop       = accept & out_sel;
        half      = accept & ~out_sel;
        // A pop frees the slot in the same edge, so a full FIFO still takes a pair.
        push      = in_valid & (~full | pop);
        drop      = in_valid & full & ~pop;
        head      = mem[rd_ptr];
        if (!out_valid)
            out_data = '0;
        else if (out_sel)
            out_data = head[15:0];
        else
            out_data = head[31:16];
    end

    // Storage has no reset; only pointers and counters define what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= {in_grv1, in_grv2};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_sel      <= 1'b0;
            fill_level   <= '0;
            overflow_cnt <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_sel      <= 1'b0;
            fill_level   <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (pop)
                out_sel <= 1'b0;
            else if (half)
                out_sel <= 1'b1;
            if (push && !pop)
                fill_level <= fill_level + 1'b1;
            else if (pop && !push)
                fill_level <= fill_level - 1'b1;
            if (drop && overflow_cnt != '1)
                overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_grv_sample_streamer.sv
// Randomised and directed bench for grv_sample_streamer against a queue-based
// model of the pair FIFO and its serialised output stream.
module tb_grv_sample_streamer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic [15:0]   in_grv1;
    logic [15:0]   in_grv2;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_sel;
    logic [AW:0]   fill_level;
    logic [15:0]   overflow_cnt;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    grv_sample_streamer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_grv1(in_grv1), .in_grv2(in_grv2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .fill_level(fill_level), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {grv1,grv2} pairs plus which half is presented.
    logic [31:0] q[$];
    bit          msel;
    int          movf;
    bit          m_has, m_pop, m_half;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            msel = 1'b0;
            movf = 0;
        end else if (clear) begin
            q.delete();
            msel = 1'b0;
            movf = 0;
        end else begin
            m_has  = (q.size() != 0);
            m_pop  = m_has && out_ready && msel;
            m_half = m_has && out_ready && !msel;
            if (m_pop) begin
                void'(q.pop_front());
                msel = 1'b0;
            end else if (m_half) begin
                msel = 1'b1;
            end
            if (in_valid) begin
                if (q.size() < DEPTH)
                    q.push_back({in_grv1, in_grv2});
                else if (movf != 65535)
                    movf++;
            end
        end
    end

    logic [63:0] exp_v, act_v;
    logic [15:0] exp_d;

    always @(negedge clk) begin
        if (started) begin
            if (q.size() == 0)
                exp_d = 16'h0000;
            else if (msel)
                exp_d = q[0][15:0];
            else
                exp_d = q[0][31:16];
            exp_v = {26'b0, q.size() != 0, msel, exp_d, 4'(q.size()), 16'(movf)};
            act_v = {26'b0, out_valid, out_sel, out_data, fill_level, overflow_cnt};
            chk("stream{valid,sel,data,fill,ovf}", act_v, exp_v);
        end
    end

    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic r, input logic c);
        in_valid  = v;
        in_grv1   = a;
        in_grv2   = b;
        out_ready = r;
        clear     = c;
        @(negedge clk);
    endtask

    logic [15:0] samp[6];
    logic [15:0] na, nb;

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_grv1 = '0; in_grv2 = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        started = 1'b1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_fill", 64'(fill_level), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        reset = 1'b1;
        step(0, '0, '0, 0, 0);

        // Single pair
        step(1, 16'h0123, 16'hFEDC, 1, 0);
        chk("single_g1", {out_sel, out_data}, {1'b0, 16'h0123});
        step(0, '0, '0, 1, 0);
        chk("single_g2", {out_sel, out_data}, {1'b1, 16'hFEDC});
        step(0, '0, '0, 1, 0);
        chk("single_empty", {out_valid, fill_level}, 64'd0);

        // Backpressure
        for (int i = 0; i < 6; i++) samp[i] = 16'($urandom);
        for (int i = 0; i < 3; i++) step(1, samp[2*i], samp[2*i+1], 0, 0);
        step(0, '0, '0, 0, 0);
        chk("bp_fill", 64'(fill_level), 64'd3);
        chk("bp_hold", 64'(out_data), 64'(samp[0]));
        for (int i = 0; i < 6; i++) begin
            chk("bp_order", 64'(out_data), 64'(samp[i]));
            step(0, '0, '0, 1, 0);
        end
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Overflow, then full with simultaneous pop
        for (int i = 0; i < 11; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
        chk("ovf_fill", 64'(fill_level), 64'd8);
        chk("ovf_cnt", 64'(overflow_cnt), 64'd3);
        step(0, '0, '0, 1, 0);
        na = 16'($urandom); nb = 16'($urandom);
        step(1, na, nb, 1, 0);
        chk("fullpop_fill", 64'(fill_level), 64'd8);
        chk("fullpop_cnt", 64'(overflow_cnt), 64'd3);
        for (int i = 0; i < 14; i++) step(0, '0, '0, 1, 0);
        chk("fullpop_last_g1", 64'(out_data), 64'(na));
        step(0, '0, '0, 1, 0);
        chk("fullpop_last_g2", 64'(out_data), 64'(nb));
        step(0, '0, '0, 1, 0);
        chk("fullpop_empty", 64'(out_valid), 64'd0);

        // Wrap-around streaming at one pair per two cycles
        step(0, '0, '0, 1, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, 16'($urandom), 16'($urandom), 1, 0);
            chk("wrap_fill_le1", 64'(fill_level <= 1), 64'd1);
            step(0, '0, '0, 1, 0);
        end
        step(0, '0, '0, 1, 0);
        chk("wrap_end", {overflow_cnt, fill_level}, 64'd0);

        // Randomised traffic with occasional clear
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 3) != 0 || i < 100 ? $urandom_range(0, 1) : 0),
                 1'($urandom_range(0, 60) == 0));

        // Clear with fill 5 and two drops
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
        for (int i = 0; i < 6; i++) step(0, '0, '0, 1, 0);
        chk("pre_clear", {overflow_cnt, fill_level}, {16'd2, 4'd5});
        step(1, 16'h1111, 16'h2222, 0, 1);
        chk("post_clear", {out_valid, out_sel, out_data, fill_level, overflow_cnt}, 64'd0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 10; i++) step(1, 16'($urandom), 16'($urandom), 0, 0);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);
        #2 reset = 1'b0;
        #1 chk("async_reset", {out_valid, out_sel, out_data, fill_level, overflow_cnt}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 16'hABCD, 16'h5555, 1, 0);
        chk("after_reset", 64'(out_data), 64'hABCD);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/grv_sample_streamer.md
# grv_sample_streamer

Downstream stage of the Box-Muller Gaussian generator. It captures each valid (grv1, grv2) sample pair into a small pair-wide FIFO and serialises it as a single 16-bit sample stream with a valid/ready handshake, grv1 first, then grv2. The generator has no backpressure, so pairs that arrive while the FIFO is full are dropped and counted. The block feeds channel-noise adders and test-capture logic that consume one sample per cycle at most.

## Interface
- DEPTH, 8, FIFO depth in sample pairs; power of two, 2..64
- AW, 3, log2(DEPTH); sizes the pointers
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush; pulses high for one cycle
- in_valid  input  1  pair strobe, driven by the generator's outputvalid
- in_grv1  input  16  signed Q-format sample 1
- in_grv2  input  16  signed Q-format sample 2
- out_valid  output  1  out_data holds a sample
- out_ready  input  1  consumer accepts the sample
- out_data  output  16  signed sample; 16'h0000 whenever out_valid=0
- out_sel  output  1  0 means out_data is grv1 of the head pair, 1 means grv2
- fill_level  output  AW+1  pairs held in the FIFO, 0..DEPTH
- overflow_cnt  output  16  count of dropped pairs; saturates at 16'hFFFF

## Operation
- Storage: DEPTH x 32-bit entries {grv1, grv2}. wr_ptr and rd_ptr are AW bits wide and wrap modulo DEPTH. The occupancy counter is AW+1 bits.
- Push condition: in_valid=1 and (fill_level<DEPTH or pop). The pair is written at wr_ptr and wr_ptr increments.
- Pop condition: out_valid & out_ready & out_sel=1. rd_ptr increments, and out_sel returns to 0 in the same edge.
- Half accept: out_valid & out_ready & out_sel=0 sets out_sel to 1. The head pair stays in the FIFO.
- Full: in_valid=1, fill_level=DEPTH and no pop in that cycle means the pair is dropped. overflow_cnt increments by 1, saturating. Pointers are unchanged.
- Simultaneous push and pop:
  - fill_level is unchanged.
  - When full, a push in the same cycle as a pop is accepted, so no drop occurs.
  - When fill_level=1, the popped pair leaves and the new pair becomes the head. out_valid stays 1.
- Empty: out_valid=0 and out_ready is ignored. A push into an empty FIFO presents that pair on the next cycle.
- Data ordering: output order is strict FIFO order. Samples appear as grv1(n), grv2(n), grv1(n+1), and so on. There is no arithmetic; sample values pass through bit-exact.
- Clear: takes priority over push, pop and half accept in the same cycle. It zeroes the pointers, fill_level, out_sel and overflow_cnt. Memory contents are not cleared. A pair presented with in_valid in the clear cycle is discarded and not counted.
- Reset (async, active-low): out_valid=0, out_data=0, out_sel=0, fill_level=0, overflow_cnt=0, pointers=0. Reset asserted mid-stream discards all contents immediately. There is no memory reset.

## Timing
- out_valid = (fill_level!=0). out_data is a combinational mux of the head entry by out_sel, gated to 0 when the FIFO is empty.
- Latency, push to presentation: a pair pushed at edge k is visible on out_data after edge k, i.e. in cycle k+1 when the FIFO was empty.
- Output side: the stream follows the AXI-style rule. Once out_valid=1, out_data and out_sel stay stable until accepted, except on clear or reset.
- Throughput:
  - Output sustains 1 sample per cycle.
  - Input sustains 1 pair per 2 cycles with out_ready held high and no loss.
  - Input bursts of up to DEPTH pairs are absorbed.
- fill_level and overflow_cnt are registered and update on the edge after the event.

## Test plan
- Single pair: after reset, push (16'h0123, 16'hFEDC) once with out_ready=1.
  - Next cycle: out_data=16'h0123, out_sel=0.
  - Following cycle: out_data=16'hFEDC, out_sel=1.
  - Then out_valid=0 and fill_level=0.
- Backpressure: push 3 pairs with out_ready=0 → fill_level=3 and out_data stays at pair0 grv1. Then raise out_ready → 6 samples out in push order on consecutive cycles.
- Overflow: DEPTH=8 with out_ready=0, push 11 pairs → fill_level=8, overflow_cnt=3. Draining yields exactly pairs 0..7.
- Full with simultaneous pop: with the FIFO full and out_sel=1, assert out_ready and in_valid together → no drop, fill_level stays 8, and the new pair is the last one drained.
- Wrap-around: stream 40 pairs at one pair per 2 cycles with out_ready=1 → 80 samples, bit-exact and in order, fill_level ≤ 1, overflow_cnt=0.
- Clear and reset: with fill_level=5 and overflow_cnt=2, pulse clear while in_valid=1 → next cycle all counters are 0 and out_valid=0. Asserting reset low mid-drain drives every output to 0 asynchronously.
